// File: rtl/piece_spawn_ctrl.sv
// ---------------------------------------------------------------------------
// piece_spawn_ctrl
//
// Purpose
//   Sequences the life of each falling piece in a block-stacking game. It asks
//   the shape queue for the next piece and waits (with a bounded timeout) for
//   the queue to answer. It then places the piece at the spawn coordinates,
//   asks the playfield whether that spot is free, and either releases the
//   piece to the player or ends the game. While a piece is under player
//   control it also handles the hold/swap key. A hold either parks the active
//   shape (and fetches a fresh one) or swaps it with the parked shape. Only
//   one hold is allowed per piece.
//
// Ports
//   Clk            in   1   single clock, rising edge
//   Reset_n        in   1   asynchronous active-low reset, release synchronised
//   start          in   1   one-cycle pulse, starts a game from IDLE
//   piece_locked   in   1   one-cycle pulse, the active piece has landed
//   keycode        in   16  current key code, 16'h0000 = no key
//   queue_shape    in   3   shape at the queue head, 1..7 valid, 0 invalid
//   queue_ack      in   1   one-cycle pulse, queue_shape answers our request
//   spawn_blocked  in   1   playfield collision answer for active_shape at spawn
//   next_req       out  1   one-cycle pulse, advance the queue
//   active_shape   out  3   shape currently under player control
//   hold_shape     out  3   parked shape, 0 = empty
//   piece_x        out  4   spawn column
//   piece_y        out  5   spawn row
//   spawn          out  1   one-cycle pulse, a new piece is live
//   game_over      out  1   level, a spawn collided
//   queue_err      out  1   level, queue timed out or delivered shape 0
// ---------------------------------------------------------------------------
module piece_spawn_ctrl #(
  parameter int          SPAWN_X     = 4,
  parameter int          SPAWN_Y     = 0,
  parameter logic [15:0] HOLD_KEY    = 16'h0013,
  parameter int          ACK_TIMEOUT = 63
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic        piece_locked,
  input  logic [15:0] keycode,
  input  logic [2:0]  queue_shape,
  input  logic        queue_ack,
  input  logic        spawn_blocked,
  output logic        next_req,
  output logic [2:0]  active_shape,
  output logic [2:0]  hold_shape,
  output logic [3:0]  piece_x,
  output logic [4:0]  piece_y,
  output logic        spawn,
  output logic        game_over,
  output logic        queue_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    ACTIVE = 3'd4,
    OVER   = 3'd5
  } state_t;

  localparam logic [5:0] CNT_MAX = 6'h3F;

  // The counter is only 6 bits wide, so a timeout beyond its range is clamped
  // to the largest count it can reach. A zero timeout would never be hit by an
  // incrementing counter, so it is treated as one cycle.
  localparam logic [5:0] TIMEOUT_LIMIT =
    (ACK_TIMEOUT >= 63) ? 6'd63 :
    (ACK_TIMEOUT <  1)  ? 6'd1  : 6'(ACK_TIMEOUT);

  localparam logic [3:0] SPAWN_X_V = 4'(SPAWN_X);
  localparam logic [4:0] SPAWN_Y_V = 5'(SPAWN_Y);

  // Reset synchroniser: assertion reaches every flop at once through the
  // async clear, while release is retimed through two flops. This keeps the
  // whole controller leaving reset on the same clock edge.
  logic rst_meta;
  logic rst_sync_n;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  state_t      state;
  state_t      state_next;
  logic        hold_used;
  logic        key_prev;
  logic [5:0]  timeout_cnt;

  logic        hold_key_now;
  logic        hold_edge;
  logic        hold_take;
  logic [5:0]  timeout_inc;

  logic        next_req_d;
  logic [2:0]  active_shape_d;
  logic [2:0]  hold_shape_d;
  logic [3:0]  piece_x_d;
  logic [4:0]  piece_y_d;
  logic        spawn_d;
  logic        game_over_d;
  logic        queue_err_d;
  logic        hold_used_d;
  logic [5:0]  timeout_cnt_d;

  // The hold request is edge-based: the key must be seen released for at
  // least one cycle before it can fire again. A hold is only honoured in
  // ACTIVE, once per piece, and never in the same cycle as a lock.
  assign hold_key_now = (keycode == HOLD_KEY);
  assign hold_edge    = hold_key_now && !key_prev;
  assign hold_take    = (state == ACTIVE) && !piece_locked && hold_edge && !hold_used;

  // Saturating increment so a long stall can never wrap back to a small count.
  assign timeout_inc  = (timeout_cnt == CNT_MAX) ? CNT_MAX : timeout_cnt + 6'd1;

  // State register and every registered output / internal flag.
  always_ff @(posedge Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state        <= IDLE;
      hold_used    <= 1'b0;
      key_prev     <= 1'b0;
      timeout_cnt  <= 6'd0;
      next_req     <= 1'b0;
      active_shape <= 3'd0;
      hold_shape   <= 3'd0;
      piece_x      <= 4'd0;
      piece_y      <= 5'd0;
      spawn        <= 1'b0;
      game_over    <= 1'b0;
      queue_err    <= 1'b0;
    end else begin
      state        <= state_next;
      hold_used    <= hold_used_d;
      key_prev     <= hold_key_now;
      timeout_cnt  <= timeout_cnt_d;
      next_req     <= next_req_d;
      active_shape <= active_shape_d;
      hold_shape   <= hold_shape_d;
      piece_x      <= piece_x_d;
      piece_y      <= piece_y_d;
      spawn        <= spawn_d;
      game_over    <= game_over_d;
      queue_err    <= queue_err_d;
    end
  end

  // Next-state logic. An ack takes priority over a timeout that expires in
  // the same cycle. A lock takes priority over a hold edge. OVER is terminal.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = REQ;
      end
      REQ: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (queue_ack) begin
          state_next = (queue_shape == 3'd0) ? OVER : CHECK;
        end else if (timeout_inc >= TIMEOUT_LIMIT) begin
          state_next = OVER;
        end
      end
      CHECK: begin
        state_next = spawn_blocked ? OVER : ACTIVE;
      end
      ACTIVE: begin
        if (piece_locked) begin
          state_next = REQ;
        end else if (hold_take) begin
          state_next = (hold_shape == 3'd0) ? REQ : CHECK;
        end
      end
      OVER: begin
        state_next = OVER;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output / datapath next values. Everything is derived from the current
  // state and the chosen transition, so the registered outputs change on the
  // same edge as the state they describe.
  always_comb begin
    next_req_d     = (state_next == REQ);
    spawn_d        = (state == CHECK) && (state_next == ACTIVE);
    game_over_d    = game_over || ((state == CHECK) && (state_next == OVER));
    queue_err_d    = queue_err || ((state == WAIT) && (state_next == OVER));
    active_shape_d = active_shape;
    hold_shape_d   = hold_shape;
    piece_x_d      = piece_x;
    piece_y_d      = piece_y;
    hold_used_d    = hold_used;
    timeout_cnt_d  = timeout_cnt;

    case (state)
      REQ: begin
        timeout_cnt_d = 6'd0;
      end
      WAIT: begin
        if (queue_ack) begin
          active_shape_d = queue_shape;
        end else begin
          timeout_cnt_d = timeout_inc;
        end
      end
      CHECK: begin
        piece_x_d = SPAWN_X_V;
        piece_y_d = SPAWN_Y_V;
      end
      ACTIVE: begin
        if (piece_locked) begin
          hold_used_d = 1'b0;
        end else if (hold_take) begin
          // Both hold flavours park the active shape; a non-empty hold also
          // brings the parked shape back into play without a queue request.
          hold_used_d  = 1'b1;
          hold_shape_d = active_shape;
          if (hold_shape != 3'd0) begin
            active_shape_d = hold_shape;
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule
